// File: rtl/usb_phy_pkg.sv
// usb_phy_pkg: constants and types shared by the USB 1.x PHY TX and RX paths.
//   Line states ({dp, dm}) for full/low speed (selected by USB_VER_1_X at use site),
//   bit time in clocks, SYNC pattern, bit-stuff limit, FSM and line-symbol encodings.
package usb_phy_pkg;

   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned BIT_CLKS_FS  = 2;
   localparam int unsigned BIT_CLKS_LS  = 16;
   localparam int unsigned BIT_CNT_W    = 4;
   localparam int unsigned ONES_W       = 3;
   localparam int unsigned STUFF_LIMIT  = 6;
   localparam logic [BYTE_W-1:0] SYNC_PATTERN = 8'h80;  // sent LSB first

   typedef logic [1:0] line_t;  // {dp, dm}

   localparam line_t LINE_SE0  = 2'b00;
   localparam line_t LINE_SE1  = 2'b11;
   localparam line_t LINE_J_FS = 2'b10;
   localparam line_t LINE_K_FS = 2'b01;
   localparam line_t LINE_J_LS = 2'b01;
   localparam line_t LINE_K_LS = 2'b10;

   function automatic line_t line_j(input bit fs);
      return fs ? LINE_J_FS : LINE_J_LS;
   endfunction

   function automatic line_t line_k(input bit fs);
      return fs ? LINE_K_FS : LINE_K_LS;
   endfunction

   function automatic int unsigned bit_clks(input bit fs);
      return fs ? BIT_CLKS_FS : BIT_CLKS_LS;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_DATA  = 3'd2,
      ST_EOP   = 3'd3,
      ST_ABORT = 3'd4
   } tx_state_e;

   // Symbol requested from the NRZI/stuff stage for the next bit time.
   typedef enum logic [2:0] {
      SYM_NONE  = 3'd0,
      SYM_BIT   = 3'd1,  // NRZI data bit, counted for stuffing
      SYM_STUFF = 3'd2,  // inserted 0
      SYM_RAW1  = 3'd3,  // held line, not counted (abort pattern)
      SYM_SE0   = 3'd4,
      SYM_J     = 3'd5
   } sym_e;

   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } tx_byte_t;

endpackage

// File: rtl/usb_phy_tx_if.sv
// usb_phy_tx_if: byte-stream handshake into the TX PHY.
//   tx_data_i/tx_valid_i/tx_last_i from the packet source, tx_ready_o from the PHY.
//   master = packet source, slave = PHY.
interface usb_phy_tx_if;

   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_last_i;
   logic       tx_ready_o;

   modport master (
      output tx_data_i,
      output tx_valid_i,
      output tx_last_i,
      input  tx_ready_o
   );

   modport slave (
      input  tx_data_i,
      input  tx_valid_i,
      input  tx_last_i,
      output tx_ready_o
   );

endinterface

// File: rtl/usb_nrzi_stuff.sv
// usb_nrzi_stuff: ones counter, stuff request, NRZI line register and SE0/J override.
//   sym_i/bit_i : symbol to place on the line (sampled when sym_i != SYM_NONE)
//   stuff_req_c : six ones counted, a stuffed 0 is owed before the next data bit
//   dp_o/dm_o   : registered line drive values
module usb_nrzi_stuff
   import usb_phy_pkg::*;
#(
   parameter bit USB_VER_1_X = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  sym_e sym_i,
   input  logic bit_i,
   output logic stuff_req_c,
   output logic dp_o,
   output logic dm_o
);

   localparam line_t LINE_J = line_j(USB_VER_1_X);
   localparam line_t LINE_K = line_k(USB_VER_1_X);

   line_t             line_q, line_d, line_tgl;
   logic [ONES_W-1:0] ones_q, ones_d;

   assign line_tgl    = (line_q == LINE_J) ? LINE_K : LINE_J;
   assign stuff_req_c = (ones_q == ONES_W'(STUFF_LIMIT));
   assign dp_o        = line_q[1];
   assign dm_o        = line_q[0];

   // NRZI: a 0 toggles the line, a 1 holds it; every non-counted symbol clears the run.
   always_comb begin
      line_d = line_q;
      ones_d = ones_q;
      case (sym_i)
         SYM_BIT: begin
            if (bit_i) begin
               ones_d = ones_q + ONES_W'(1);
            end else begin
               ones_d = '0;
               line_d = line_tgl;
            end
         end
         SYM_STUFF: begin
            ones_d = '0;
            line_d = line_tgl;
         end
         SYM_RAW1: ones_d = '0;
         SYM_SE0: begin
            ones_d = '0;
            line_d = LINE_SE0;
         end
         SYM_J: begin
            ones_d = '0;
            line_d = LINE_J;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_q <= LINE_J;
         ones_q <= '0;
      end else begin
         line_q <= line_d;
         ones_q <= ones_d;
      end
   end

endmodule

// File: rtl/usb_phy_tx.sv
// usb_phy_tx: USB 1.x low/full-speed transmit PHY.
//   tx_if (slave)  : packet bytes PID..CRC, LSB first, valid/ready with last marker
//   tx_busy_o      : SYNC..EOP in progress
//   tx_done_o      : 1-clk pulse as EOP completes (same cycle oe falls)
//   tx_underrun_o  : 1-clk pulse, holding register empty at a byte boundary without last
//   usb_tx_oe_o/usb_tx_dp_o/usb_tx_dm_o : transceiver drive
// Optional build macro USB_PHY_TX_ABORT_STUFF_ERR_EN: on underrun send 8 unstuffed
// held bits (a deliberate stuff error) before EOP; otherwise go straight to EOP.
module usb_phy_tx
   import usb_phy_pkg::*;
#(
   parameter bit USB_VER_1_X = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   usb_phy_tx_if.slave tx_if,
   output logic        tx_busy_o,
   output logic        tx_done_o,
   output logic        tx_underrun_o,
   output logic        usb_tx_oe_o,
   output logic        usb_tx_dp_o,
   output logic        usb_tx_dm_o
);

   localparam int unsigned P_BIT_CLKS = bit_clks(USB_VER_1_X);
   localparam int unsigned IDX_W      = 3;
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(BYTE_W - 1);
   localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(P_BIT_CLKS - 1);

   tx_state_e            state_q, state_d;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
   tx_byte_t             shift_q, shift_d, hold_q, hold_d, in_byte;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 oe_q, oe_d;
   logic                 done_q, done_d;
   logic                 underrun_q, underrun_d;
   logic                 accept, bit_en, stuff_req_c;
   sym_e                 sym;
   logic                 sym_bit;

   assign in_byte = {tx_if.tx_last_i, tx_if.tx_data_i};
   assign accept  = tx_if.tx_valid_i & ready_q;
   assign bit_en  = (cnt_q == CNT_LAST);
   assign idx_inc = idx_q + IDX_W'(1);

   assign tx_if.tx_ready_o = ready_q;
   assign tx_busy_o        = busy_q;
   assign tx_done_o        = done_q;
   assign tx_underrun_o    = underrun_q;
   assign usb_tx_oe_o      = oe_q;

   // Next-state logic: each bit_en edge picks the symbol for the following bit time.
   // ready stays low once the last byte is taken, so nothing leaks into the next packet.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      ready_d    = ready_q;
      busy_d     = busy_q;
      oe_d       = oe_q;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      sym        = SYM_NONE;
      sym_bit    = 1'b0;

      if (state_q != ST_IDLE) begin
         cnt_d = bit_en ? '0 : cnt_q + BIT_CNT_W'(1);
      end

      if (accept) begin
         hold_d  = in_byte;
         ready_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SYNC;
               cnt_d   = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               oe_d    = 1'b1;
               sym     = SYM_BIT;
               sym_bit = SYNC_PATTERN[0];
            end
         end

         ST_SYNC: begin
            if (bit_en) begin
               if (idx_q != IDX_LAST) begin
                  idx_d   = idx_inc;
                  sym     = SYM_BIT;
                  sym_bit = SYNC_PATTERN[idx_inc];
               end else begin
                  state_d = ST_DATA;
                  shift_d = hold_q;
                  ready_d = !hold_q.last;
                  idx_d   = '0;
                  sym     = SYM_BIT;
                  sym_bit = hold_q.data[0];
               end
            end
         end

         ST_DATA: begin
            if (bit_en) begin
               if (stuff_req_c) begin
                  sym = SYM_STUFF;
               end else if (idx_q != IDX_LAST) begin
                  idx_d   = idx_inc;
                  sym     = SYM_BIT;
                  sym_bit = shift_q.data[idx_inc];
               end else if (shift_q.last) begin
                  state_d = ST_EOP;
                  idx_d   = '0;
                  ready_d = 1'b0;
                  sym     = SYM_SE0;
               end else if (!ready_q) begin
                  shift_d = hold_q;
                  ready_d = !hold_q.last;
                  idx_d   = '0;
                  sym     = SYM_BIT;
                  sym_bit = hold_q.data[0];
               end else if (accept) begin
                  // Byte arriving exactly on the boundary goes straight to the shifter.
                  shift_d = in_byte;
                  ready_d = !in_byte.last;
                  idx_d   = '0;
                  sym     = SYM_BIT;
                  sym_bit = in_byte.data[0];
               end else begin
                  underrun_d = 1'b1;
                  ready_d    = 1'b0;
                  idx_d      = '0;
`ifdef USB_PHY_TX_ABORT_STUFF_ERR_EN
                  state_d    = ST_ABORT;
                  sym        = SYM_RAW1;
`else
                  state_d    = ST_EOP;
                  sym        = SYM_SE0;
`endif
               end
            end
         end

         ST_ABORT: begin
            if (bit_en) begin
               if (idx_q != IDX_LAST) begin
                  idx_d = idx_inc;
                  sym   = SYM_RAW1;
               end else begin
                  state_d = ST_EOP;
                  idx_d   = '0;
                  sym     = SYM_SE0;
               end
            end
         end

         ST_EOP: begin
            // idx 0,1: SE0 on the line; idx 2: J on the line.
            if (bit_en) begin
               if (idx_q == IDX_W'(0)) begin
                  idx_d = IDX_W'(1);
                  sym   = SYM_SE0;
               end else if (idx_q == IDX_W'(1)) begin
                  idx_d = IDX_W'(2);
                  sym   = SYM_J;
               end else begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  cnt_d   = '0;
                  oe_d    = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         oe_q       <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         oe_q       <= oe_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   usb_nrzi_stuff #(
      .USB_VER_1_X (USB_VER_1_X)
   ) u_nrzi_stuff (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .sym_i       (sym),
      .bit_i       (sym_bit),
      .stuff_req_c (stuff_req_c),
      .dp_o        (usb_tx_dp_o),
      .dm_o        (usb_tx_dm_o)
   );

endmodule

// File: doc/usb_phy_tx.md
Name: usb_phy_tx

Overview:
USB 1.x low/full-speed transmit PHY: the TX counterpart of the RX path in the USB PHY.
- Accepts packet bytes (PID..CRC) over a valid/ready byte stream.
- Prepends SYNC, serialises LSB-first, bit-stuffs, NRZI-encodes, appends EOP.
- Drives D+/D- plus output enable for the external transceiver.

Parameters:
USB_VER_1_X, 1, 1: full speed (12 Mbps, bit time 2 clk @24 MHz, J=dp1/dm0); 0: low speed (1.5 Mbps, bit time 16 clk, J=dp0/dm1)

Ports:
- clk_i  in  1  24 MHz system clock
- rst_ni  in  1  reset; asynchronous, active-low
- tx_data_i  in  8  packet byte, sent LSB first
- tx_valid_i  in  1  byte valid
- tx_last_i  in  1  byte is last of packet (qualified by tx_valid_i)
- tx_ready_o  out  1  byte accepted when tx_valid_i & tx_ready_o
- tx_busy_o  out  1  packet in progress (SYNC..EOP)
- tx_done_o  out  1  1-clk pulse when EOP completes
- tx_underrun_o  out  1  1-clk pulse: holding register empty at byte boundary without last
- usb_tx_oe_o  out  1  1: drive bus, 0: hi-z
- usb_tx_dp_o  out  1  D+ drive value
- usb_tx_dm_o  out  1  D- drive value

Behaviour:
- Reset (async, any time incl. mid-packet): oe=0, dp/dm=J, ready=1, busy/done/underrun=0, FSM=IDLE, holding register empty.
- Bit-enable counter runs only when not IDLE; it restarts at 0 on packet start.
- Every line symbol is held exactly P_BIT_CLKS clocks (2 FS / 16 LS).
- Handshake:
  - One-byte holding register plus 8-bit shift register.
  - tx_ready_o = holding register empty.
  - Shift register reloads from the holding register at the byte boundary, after the 8th non-stuff bit.
- FSM IDLE -> SYNC -> DATA -> EOP -> IDLE. Encoding: IDLE=0, SYNC=1, DATA=2, EOP=3, ABORT=4.
- IDLE: a byte accepted in cycle N starts the packet.
  - Cycle N+1: oe=1, busy=1, first K driven.
- SYNC: 8 bits 0000_0001 NRZI-encoded -> line KJKJKJKK.
  - The final 1 of SYNC seeds the ones-counter to 1.
- DATA:
  - NRZI: a 0 toggles the line (J<->K); a 1 holds it.
  - Ones-counter increments on a 1 and clears on a 0 or on a stuffed bit.
  - When the counter reaches 6, a stuffed 0 is inserted before the next data bit. No shift advance; it still occupies one bit time.
  - A stuff bit owed after the final data bit is sent before EOP.
- Byte boundary, holding register empty:
  - Shifted byte carried last -> go to EOP.
  - Otherwise -> tx_underrun_o pulse, go to ABORT.
- EOP: SE0 for 2 bit times, then J for 1 bit time.
  - Then oe=0, busy=0, tx_done_o=1 in the same cycle; next state IDLE.
- Packet length in bit times = 8 + 8*bytes + stuffs + 3.
- A new packet may be accepted the cycle after tx_done_o.
- tx_valid_i while holding register full: ignored (no accept). tx_last_i on the first byte gives a 1-byte packet.
- usb_tx_dp_o/usb_tx_dm_o are registered. SE1 is never driven.

Optional Feature:
USB_PHY_TX_ABORT_STUFF_ERR_EN
- Defined: ABORT sends 8 consecutive 1 bits with stuffing disabled (a deliberate bit-stuff error per USB abort), then EOP.
- Undefined: ABORT goes directly to EOP.
- tx_underrun_o is identical in both builds.

Decomposition:
- Package usb_phy_pkg:
  - SE0/J/K/SE1 line-state constants selected by USB_VER_1_X.
  - FSM state encodings.
  - P_BIT_CLKS.
  - SYNC pattern 8'h80 (LSB first).
  - Stuff limit 6.
- Sub-module usb_nrzi_stuff holds the ones-counter, stuff-insert request, NRZI line register and SE0/J override. It shares the package with the RX side.
- usb_phy_tx owns the handshake, shift/holding registers, bit-enable counter and FSM.

Test Plan:
- FS, single byte 0xD2 last:
  - Line KJKJKJKK, JJKJJKKK, SE0 SE0 J.
  - oe high 38 clk; tx_done_o on the clk oe falls; ready=1 afterwards.
- FS, bytes 0xFF, 0xFF (second last):
  - Stuffed transitions after data bits 5 and 11.
  - 29 bit times = 58 clk.
  - No 7 consecutive identical symbols.
- FS, single byte 0xFC last: stuff bit inserted after the 6 trailing ones, before EOP; 20 bit times = 40 clk.
- LS (USB_VER_1_X=0), byte 0xD2 last:
  - Same symbol sequence with J=dp0/dm1.
  - Each symbol 16 clk; total 304 clk.
- FS, byte 0x69 with no last, valid dropped:
  - tx_underrun_o pulse at byte boundary.
  - With macro: 8 held symbols then EOP. Without: EOP immediately.
  - done pulses in both.
- Reset asserted mid-DATA: same cycle oe=0, dp/dm=J, busy=0. After release a new 0xD2 packet transmits correctly.
